// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster-timing definitions.
//   axis_mode_t / video_mode_t : per-axis active/porch/sync geometry plus sync polarity
//   VGA_640x480, SVGA_800x600  : ready-made modes for parameter overrides
//   axis_total()               : total counts per axis (active + porches + sync)
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_mode_t;

    typedef struct packed {
        axis_mode_t h;
        axis_mode_t v;
        logic       sync_pol;
    } video_mode_t;

    localparam video_mode_t VGA_640x480 = '{
        '{640, 16, 96, 48},
        '{480, 10, 2, 33},
        1'b0
    };

    localparam video_mode_t SVGA_800x600 = '{
        '{800, 40, 128, 88},
        '{600, 1, 4, 23},
        1'b1
    };

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   i_clk, i_rst (sync, active-high), i_en (advance one position)
//   count     : current position 0..TOTAL-1
//   wrap      : count is TOTAL-1, so the next enable returns to 0
//   in_sync   : registered, current position lies in the sync interval
//   in_active : registered, current position lies in the active interval
// ACTIVE_FIRST=0 orders the axis FP,SYNC,BP,ACTIVE; ACTIVE_FIRST=1 orders it
// ACTIVE,FP,SYNC,BP.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE       = 640,
    parameter int unsigned FP           = 16,
    parameter int unsigned SYNC         = 96,
    parameter int unsigned BP           = 48,
    parameter bit          ACTIVE_FIRST = 1'b0,
    localparam int unsigned TOTAL       = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int unsigned CW          = $clog2(TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active
);

    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE_FIRST ? ACTIVE + FP : FP);
    localparam logic [CW-1:0] SYNC_HI = CW'((ACTIVE_FIRST ? ACTIVE + FP : FP) + SYNC);
    // Active-first axes end their active span at ACTIVE; active-last axes
    // start it at FP+SYNC+BP and run to the end of the axis.
    localparam logic [CW-1:0] ACT_HI  = CW'(ACTIVE);
    localparam logic [CW-1:0] ACT_LO  = CW'(FP + SYNC + BP);

    logic [CW-1:0] count_nx;
    logic          sync_nx;
    logic          active_nx;

    assign wrap = (count == LAST);

    always_comb begin
        count_nx  = wrap ? '0 : count + CW'(1);
        sync_nx   = (count_nx >= SYNC_LO) && (count_nx < SYNC_HI);
        active_nx = ACTIVE_FIRST ? (count_nx < ACT_HI) : (count_nx >= ACT_LO);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count     <= '0;
            in_sync   <= 1'b0;
            in_active <= ACTIVE_FIRST;
        end else if (i_en) begin
            count     <= count_nx;
            in_sync   <= sync_nx;
            in_active <= active_nx;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
//   i_clk, i_rst (sync, active-high), i_pix_stb (advance one pixel)
//   o_hs, o_vs     : sync outputs, asserted level = SYNC_POL
//   o_de           : inside the active area
//   o_x, o_y       : active coordinates (x=0 / y=V_ACTIVE-1 outside active)
//   o_line_start   : one-clock pulse when h returns to 0
//   o_frame_start  : one-clock pulse when (h,v) returns to (0,0)
//   o_animate      : one-clock pulse when leaving the last active line
//   o_frame        : frame counter, present only with VGA_TIMING_FRAME_CNT_EN
// All outputs describe the current (h,v) position.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
    parameter int unsigned H_FP     = VGA_640x480.h.fp,
    parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
    parameter int unsigned H_BP     = VGA_640x480.h.bp,
    parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
    parameter int unsigned V_FP     = VGA_640x480.v.fp,
    parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
    parameter int unsigned V_BP     = VGA_640x480.v.bp,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_pix_stb,
    output logic                        o_hs,
    output logic                        o_vs,
    output logic                        o_de,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_line_start,
    output logic                        o_frame_start,
    output logic                        o_animate
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0]          o_frame
`endif
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned YW      = $clog2(V_ACTIVE);
    localparam logic        POL     = (SYNC_POL != 0);

    // Last h position before the active span begins.
    localparam logic [HCW-1:0] H_ACT_PRE  = HCW'(H_TOTAL - H_ACTIVE - 1);
    localparam logic [VCW-1:0] V_ACT_LAST = VCW'(V_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(V_ACTIVE - 1);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        FRAME_W < 1 || SYNC_POL > 1) begin : g_bad_param
        $error("vga_timing_gen: every parameter must be >= 1 and SYNC_POL 0 or 1");
    end

    logic [HCW-1:0] h_count;
    logic [VCW-1:0] v_count;
    logic           h_wrap, v_wrap;
    logic           h_in_sync, v_in_sync;
    logic           h_in_active, v_in_active;
    logic           v_en;

    assign v_en = i_pix_stb & h_wrap;

    vga_axis_counter #(
        .ACTIVE       (H_ACTIVE),
        .FP           (H_FP),
        .SYNC         (H_SYNC),
        .BP           (H_BP),
        .ACTIVE_FIRST (1'b0)
    ) u_h (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_pix_stb),
        .count     (h_count),
        .wrap      (h_wrap),
        .in_sync   (h_in_sync),
        .in_active (h_in_active)
    );

    vga_axis_counter #(
        .ACTIVE       (V_ACTIVE),
        .FP           (V_FP),
        .SYNC         (V_SYNC),
        .BP           (V_BP),
        .ACTIVE_FIRST (1'b1)
    ) u_v (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (v_en),
        .count     (v_count),
        .wrap      (v_wrap),
        .in_sync   (v_in_sync),
        .in_active (v_in_active)
    );

    // Sync flags are already registered per position; polarity is a constant.
    assign o_hs = h_in_sync ? POL : ~POL;
    assign o_vs = v_in_sync ? POL : ~POL;

    logic          h_act_nx, v_act_nx;
    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;

    // Decode of the position the next strobe will move to, so the output
    // registers land together with the counters.
    always_comb begin
        h_act_nx = h_wrap ? 1'b0 : (h_in_active || h_count == H_ACT_PRE);
        v_act_nx = h_wrap ? (v_wrap || v_count < V_ACT_LAST) : v_in_active;
        x_nx     = h_act_nx ? XW'(h_count - H_ACT_PRE) : '0;
        y_nx     = o_y;
        if (h_wrap) begin
            if (v_wrap)
                y_nx = '0;
            else if (v_count < V_ACT_LAST)
                y_nx = YW'(v_count + VCW'(1));
            else
                y_nx = Y_LAST;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_animate     <= 1'b0;
        end else begin
            o_line_start  <= i_pix_stb & h_wrap;
            o_frame_start <= i_pix_stb & h_wrap & v_wrap;
            o_animate     <= i_pix_stb & h_wrap & (v_count == V_ACT_LAST);
            if (i_pix_stb) begin
                o_de <= h_act_nx & v_act_nx;
                o_x  <= x_nx;
                o_y  <= y_nx;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_frame <= '0;
        else if (i_pix_stb & h_wrap & v_wrap)
            o_frame <= o_frame + FRAME_W'(1);
    end
`else
    // No frame counter in this build; FRAME_W is only range-checked.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Compact mode so whole frames fit in a short run.
    localparam int unsigned HA = 10, HF = 2, HS = 3, HB = 4;
    localparam int unsigned VA = 5,  VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;   // 19
    localparam int unsigned VT = VA + VF + VS + VB;   // 12
    localparam int unsigned FW = 2;
    localparam logic        P  = 1'b0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          hs, vs, de, ls, fs, an;
    logic [3:0]    x;
    logic [2:0]    y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FW-1:0] frame;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (0),  .FRAME_W (FW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_stb     (stb),
        .o_hs          (hs),
        .o_vs          (vs),
        .o_de          (de),
        .o_x           (x),
        .o_y           (y),
        .o_line_start  (ls),
        .o_frame_start (fs),
        .o_animate     (an)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .o_frame       (frame)
`endif
    );

    typedef struct {
        logic hs, vs, de, ls, fs, an;
        int   x, y, frame;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   mh = 0, mv = 0, mframe = 0;
    int   errors = 0, checks = 0;
    int   n_ls, n_fs, n_an, n_hs, n_de;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference raster model, advanced once per driven clock.
    task automatic model_step(input logic r, input logic s);
        int  oh, ov;
        bit  hact, vact;
        cur.ls = 1'b0;
        cur.fs = 1'b0;
        cur.an = 1'b0;
        if (r) begin
            mh = 0; mv = 0; mframe = 0;
            cur.hs = ~P; cur.vs = ~P; cur.de = 1'b0; cur.x = 0; cur.y = 0;
        end else if (s) begin
            oh = mh; ov = mv;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            hact   = (mh >= HT - HA);
            vact   = (mv < VA);
            cur.hs = (mh >= HF && mh < HF + HS) ? P : ~P;
            cur.vs = (mv >= VA + VF && mv < VA + VF + VS) ? P : ~P;
            cur.de = hact && vact;
            cur.x  = hact ? mh - (HT - HA) : 0;
            cur.y  = vact ? mv : VA - 1;
            cur.ls = (mh == 0);
            cur.fs = (mh == 0 && mv == 0);
            cur.an = (oh == HT - 1 && ov == VA - 1);
            if (cur.fs) mframe = (mframe + 1) % (1 << FW);
        end
        cur.frame = mframe;
    endtask

    task automatic compare(input exp_t e);
        check("hs", hs, e.hs);
        check("vs", vs, e.vs);
        check("de", de, e.de);
        check("x", x, e.x);
        check("y", y, e.y);
        check("line_start", ls, e.ls);
        check("frame_start", fs, e.fs);
        check("animate", an, e.an);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame", frame, e.frame);
`endif
        n_ls += int'(ls === 1'b1);
        n_fs += int'(fs === 1'b1);
        n_an += int'(an === 1'b1);
        n_hs += int'(hs === P);
        n_de += int'(de === 1'b1);
    endtask

    // One clock: score the previous edge, then drive and predict the next.
    task automatic cycle(input logic r, input logic s);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            compare(e);
        end
        rst = r;
        stb = s;
        model_step(r, s);
        q.push_back(cur);
    endtask

    task automatic clear_counts();
        n_ls = 0; n_fs = 0; n_an = 0; n_hs = 0; n_de = 0;
    endtask

    initial begin
        clear_counts();

        // Reset held three clocks with the strobe active.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

        // Two full frames, strobe every clock.
        cycle(1'b0, 1'b1);
        clear_counts();
        for (int i = 1; i < 2 * HT * VT; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("frames_fs_count", n_fs, 2);
        check("frames_an_count", n_an, 2);
        check("frames_ls_count", n_ls, 2 * VT);
        check("frames_hs_cycles", n_hs, 2 * VT * HS);
        check("frames_de_cycles", n_de, 2 * VA * HA);

        // One frame with the strobe 1-in-4: every period stretches by four.
        clear_counts();
        for (int i = 0; i < 4 * HT * VT; i++) cycle(1'b0, (i % 4) == 3);
        cycle(1'b0, 1'b0);
        check("gated_fs_count", n_fs, 1);
        check("gated_an_count", n_an, 1);
        check("gated_ls_count", n_ls, VT);
        check("gated_hs_cycles", n_hs, 4 * VT * HS);

        // Random strobe pattern.
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'($urandom_range(0, 1)));

        // Seek to a mid-frame position (bounded), then reset there.
        for (int i = 0; i < HT * VT + 2; i++) begin
            if (mh == 7 && mv == 3) break;
            cycle(1'b0, 1'b1);
        end
        check("seek_reached", (mh == 7 && mv == 3), 1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        clear_counts();
        for (int i = 0; i < HT * VT + 40; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("restart_fs_count", n_fs, 1);
        check("restart_an_count", n_an, 1);

        // Drain the last prediction.
        begin
            exp_t e;
            @(negedge clk);
            e = q.pop_front();
            compare(e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
